// File: rtl/uart_loop_fifo.sv
// UART echo path: received bytes are queued in a FIFO and replayed to the
// transmitter one at a time with a send strobe and busy/ack handshake.
module uart_loop_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned ACK_TO     = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  recv_done,
    input  logic [DATA_W-1:0]     recv_data,
    input  logic                  uart_tx_busy,
    input  logic                  loop_en,
    input  logic                  flush,
    input  logic                  clr_ovf,
    output logic                  send_en,
    output logic [DATA_W-1:0]     send_data,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned TMR_W = (ACK_TO > 2) ? $clog2(ACK_TO) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [TMR_W-1:0]    timer;
    logic                recv_done_d;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr_nxt;
    logic [PTR_W-1:0]    rd_ptr_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic empty;
    logic full;
    logic wr_req;
    logic pop;
    logic wr_accept;
    logic ovf_set;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                       (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign wr_req    = recv_done & ~recv_done_d & loop_en & ~flush;
    assign pop       = (state == IDLE) & ~empty & ~uart_tx_busy & loop_en & ~flush;
    assign wr_accept = wr_req & (~full | pop);
    assign ovf_set   = wr_req & full & ~pop;

    // Next pointer values; flush discards everything queued up to now
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            rd_ptr_nxt = wr_ptr;
        end else begin
            if (wr_accept) wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (pop)       rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
    end

    // Storage array carries no reset; the pointers define what is valid
    always_ff @(posedge sys_clk) begin
        if (wr_accept) mem[wr_ptr[DEPTH_LOG2-1:0]] <= recv_data;
    end

    // FIFO bookkeeping, overflow flag and transmit handshake FSM
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            recv_done_d <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            overflow    <= 1'b0;
            state       <= IDLE;
            timer       <= '0;
            send_en     <= 1'b0;
            send_data   <= '0;
        end else begin
            recv_done_d <= recv_done;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            fifo_count  <= wr_ptr_nxt - rd_ptr_nxt;

            if (ovf_set)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;

            case (state)
                IDLE: begin
                    send_en <= 1'b0;
                    if (pop) begin
                        send_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                        send_en   <= 1'b1;
                        timer     <= '0;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    send_en <= 1'b0;
                    // A transmitter that never shows busy still releases us
                    if (uart_tx_busy)                        state <= WAIT_DONE;
                    else if (timer == TMR_W'(ACK_TO - 1))    state <= IDLE;
                    else                                     timer <= timer + TMR_W'(1);
                end
                WAIT_DONE: begin
                    send_en <= 1'b0;
                    if (!uart_tx_busy) state <= IDLE;
                end
                default: begin
                    send_en <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_loop_fifo.md
# uart_loop_fifo

Parametrised UART echo block: every byte delivered by the UART receiver is pushed into an internal FIFO and replayed to the UART transmitter with a one-cycle send strobe and a busy-aware handshake. It sits between the receiver and transmitter in the loopback top level, in place of the single-register echo path. It absorbs back-to-back received bytes while the transmitter is busy, reports fill level and a sticky overflow, and supports pause and flush control.

## Interface
- DATA_W, 8, width of recv_data/send_data
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16)
- ACK_TO, 16, cycles to wait for uart_tx_busy to rise after send_en before giving up (≥2)

- sys_clk  in  1  clock, all logic on rising edge
- sys_rst_n  in  1  reset, asynchronous, active-low
- recv_done  in  1  receiver byte-complete, level or pulse; rising edge means new byte
- recv_data  in  DATA_W  received byte, valid while recv_done high
- uart_tx_busy  in  1  transmitter busy
- loop_en  in  1  1 = echo enabled; 0 = discard input, pause output
- flush  in  1  synchronous FIFO clear
- clr_ovf  in  1  clears overflow
- send_en  out  1  one-cycle transmit strobe
- send_data  out  DATA_W  byte to transmit, held stable until next load
- fifo_count  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
- overflow  out  1  sticky: a byte was dropped because FIFO full

## Operation
- Reset: send_en=0, send_data=0, fifo_count=0, overflow=0, pointers=0, FSM=IDLE.
- Edge detect: recv_done registered once (recv_done_d, reset 0); wr_req = recv_done & ~recv_done_d & loop_en & ~flush. A held-high recv_done yields exactly one write.
- Write: on wr_req, recv_data written at wr_ptr, wr_ptr++ (wraps mod 2**DEPTH_LOG2).
- Full: wr_req with count = 2**DEPTH_LOG2 and no pop on the same edge → byte dropped, overflow<=1. Full with a same-edge pop → write accepted, count unchanged.
- Pointers carry DEPTH_LOG2+1 bits; full/empty come from the MSB compare; fifo_count = wr_ptr - rd_ptr.
- overflow: set has priority over clr_ovf on the same edge.
- flush: rd_ptr<=wr_ptr, so count=0 next cycle. Any same-cycle write/pop is suppressed. An in-flight transmit is not aborted.
- loop_en=0: no writes (not counted as overflow). FSM takes no new pop from IDLE. FIFO contents are retained. In-flight send completes.
- FSM states:
  - IDLE: if count>0 & ~uart_tx_busy & loop_en → pop head into send_data, send_en<=1, timer<=0, go to WAIT_ACK.
  - WAIT_ACK: send_en<=0. If uart_tx_busy → WAIT_DONE. Else if timer = ACK_TO-1 → IDLE (byte considered sent). Else timer++.
  - WAIT_DONE: when ~uart_tx_busy → IDLE.
- Only one byte is in flight at a time. send_en is never high on two consecutive cycles.

## Timing
- recv_done rising sampled at edge E0 → written at E0, count=1 after E0.
- At E1 IDLE pops → send_en high for exactly the cycle after E1, send_data valid at the same time. Input-to-strobe latency is 2 edges with the FSM idle and the transmitter free.
- Minimum spacing between send_en pulses: 3 cycles (IDLE→WAIT_ACK→WAIT_DONE→IDLE), plus transmitter busy time.
- Simultaneous write and pop: count unchanged. A write into an empty FIFO is not poppable until the next edge (no bypass).
- Asynchronous reset mid-transfer: all state cleared immediately. FIFO contents are lost and send_en drops to 0.

## Test plan
- Single byte: recv_done pulse with 0xA5, tx idle → send_en high 1 cycle, 2 edges later, send_data=0xA5; fifo_count 0→1→0.
- Burst: 5 bytes 0x01..0x05 each 2 cycles apart, tx busy 100 cycles per byte after send_en → 5 send_en pulses in order 0x01..0x05, no overflow, peak fifo_count ≥4.
- Overflow: tx busy held high, 17 distinct bytes written → fifo_count=16, overflow=1, first 16 bytes later emitted in order, 17th absent. clr_ovf → overflow=0.
- Held level: recv_done high for 10 cycles with 0x3C → exactly one write, one send_en.
- Ack timeout: uart_tx_busy tied 0, 2 bytes queued → send_en pulses spaced ACK_TO+1 cycles apart, data 1st then 2nd.
- Pause/flush: loop_en=0 with 3 bytes queued → no send_en and new recv_done ignored. Flush → count=0. loop_en=1 → no sends. Reset during WAIT_DONE → all outputs at reset values.
